// File: rtl/if2_id_fetch_queue.sv
// IF2 -> ID fetch queue: a circular buffer of single-instruction entries that
// accepts whole IF2 packets and hands one instruction per cycle to decode.
module if2_id_fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int FETCH_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      if2_valid,
    output logic                      if2_ready,
    input  logic [FETCH_W-1:0]        if2_lane_valid,
    input  logic [32*FETCH_W-1:0]     if2_pc,
    input  logic [32*FETCH_W-1:0]     if2_inst,
    input  logic [FETCH_W-1:0]        if2_icache_hit,
    input  logic [FETCH_W-1:0]        if2_branch_bp,
    input  logic                      if1_if2_cache_valid,
    output logic                      id_valid,
    input  logic                      id_ready,
    output logic [31:0]               id_pc,
    output logic [31:0]               id_inst,
    output logic                      id_icache_hit,
    output logic                      id_branch_bp,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Room for a full packet exists exactly when occupancy is at most this.
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - FETCH_W);

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];
    logic        hit_mem  [DEPTH];
    logic        bp_mem   [DEPTH];

    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [FETCH_W-1:0] lane_take;
    logic [PTR_W-1:0]   lane_addr [FETCH_W];
    logic [CNT_W-1:0]   push_n;
    logic               run;
    logic               push_fire;
    logic               pop_fire;

    // Only the unbroken run of valid lanes starting at lane 0 is taken.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        lane_take = '0;
        push_n    = '0;
        run       = 1'b1;
        for (int i = 0; i < FETCH_W; i++) begin
            run          = run & if2_lane_valid[i];
            lane_take[i] = run;
            push_n       = push_n + CNT_W'(run);
            lane_addr[i] = wr_ptr + PTR_W'(i);
        end
    end

    assign if2_ready = (count <= READY_MAX);
    assign push_fire = if2_valid & if2_ready & ~flush & (push_n != '0);
    assign pop_fire  = id_valid & id_ready & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PTR_W'(push_n);
            if (pop_fire)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (push_fire ? push_n : '0) - CNT_W'(pop_fire);
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale data is never seen.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (push_fire && lane_take[i]) begin
                pc_mem[lane_addr[i]]   <= if2_pc[32*i +: 32];
                inst_mem[lane_addr[i]] <= if1_if2_cache_valid ? if2_inst[32*i +: 32] : 32'h0;
                hit_mem[lane_addr[i]]  <= if1_if2_cache_valid & if2_icache_hit[i];
                bp_mem[lane_addr[i]]   <= if2_branch_bp[i];
            end
        end
    end

    // Head is read straight from storage, which holds still while ID stalls.
    assign id_valid      = (count != '0);
    assign id_pc         = id_valid ? pc_mem[rd_ptr]   : 32'h0;
    assign id_inst       = id_valid ? inst_mem[rd_ptr] : 32'h0;
    assign id_icache_hit = id_valid & hit_mem[rd_ptr];
    assign id_branch_bp  = id_valid & bp_mem[rd_ptr];

endmodule
